// File: rtl/phase_timer.sv
// Phase timer for the two-road traffic-light controller: times the phase selected by
// the one-hot C1/C2/C3 strobes and returns a 1-clk W1/W2/W3 "phase expired" pulse.
// Ports: clk/reset (sync, active-low); C1..C3 phase select; car2 side-road detector;
//        hold freezes the timer; W1..W3 expiry pulses; count, car_pending, sel_err status.
module phase_timer #(
  parameter int CW = 4,
  parameter int T1 = 8,
  parameter int T2 = 3,
  parameter int T3 = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          C1,
  input  logic          C2,
  input  logic          C3,
  input  logic          car2,
  input  logic          hold,
  output logic          W1,
  output logic          W2,
  output logic          W3,
  output logic [CW-1:0] count,
  output logic          car_pending,
  output logic          sel_err
);

  localparam logic [2:0] SEL_MAIN = 3'b001;
  localparam logic [2:0] SEL_YEL  = 3'b010;
  localparam logic [2:0] SEL_SIDE = 3'b100;

  logic [2:0]    sel;
  logic          entry;
  logic          one_hot;
  logic [CW-1:0] lim_m1;

  logic [2:0]    sel_q, sel_d;
  logic [CW-1:0] count_q, count_d;
  logic          fired_q, fired_d;
  logic [2:0]    w_q, w_d;
  logic          car_pending_q, car_pending_d;
  logic          sel_err_q, sel_err_d;

  always_comb begin
    sel     = {C3, C2, C1};
    entry   = (sel != sel_q);
    one_hot = (sel == SEL_MAIN) || (sel == SEL_YEL) || (sel == SEL_SIDE);

    // Terminal count for the selected phase; illegal selects never reach expiry.
    case (sel)
      SEL_MAIN: lim_m1 = CW'(T1 - 1);
      SEL_YEL:  lim_m1 = CW'(T2 - 1);
      default:  lim_m1 = CW'(T3 - 1);
    endcase

    sel_d         = sel;
    count_d       = count_q;
    fired_d       = fired_q;
    w_d           = 3'b000;
    car_pending_d = car_pending_q;
    sel_err_d     = sel_err_q | ~one_hot;

    // Request latch: entering side-green consumes the request, and wins over a new one.
    if (!hold && car2) car_pending_d = 1'b1;
    if (entry && (sel == SEL_SIDE)) car_pending_d = 1'b0;

    if (sel_err_d) begin
      // Illegal select seen: timer parked at zero, no expiry until reset.
      count_d = '0;
    end else if (entry) begin
      count_d = '0;
      fired_d = 1'b0;
    end else if (!hold) begin
      if (count_q < lim_m1) begin
        count_d = count_q + 1'b1;
      end else if (!fired_q && ((sel != SEL_MAIN) || car_pending_q)) begin
        // One pulse per phase; main green additionally waits for a side request.
        w_d     = sel;
        fired_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sel_q         <= 3'b000;
      count_q       <= '0;
      fired_q       <= 1'b0;
      w_q           <= 3'b000;
      car_pending_q <= 1'b0;
      sel_err_q     <= 1'b0;
    end else begin
      sel_q         <= sel_d;
      count_q       <= count_d;
      fired_q       <= fired_d;
      w_q           <= w_d;
      car_pending_q <= car_pending_d;
      sel_err_q     <= sel_err_d;
    end
  end

  assign W1          = w_q[0];
  assign W2          = w_q[1];
  assign W3          = w_q[2];
  assign count       = count_q;
  assign car_pending = car_pending_q;
  assign sel_err     = sel_err_q;

endmodule
